sensor_frame_decoder: RTL

Receive-side decoder for the sensor telemetry stream. Consumes bytes from a UART receiver (one byte per `rx_valid` pulse), parses the 8-byte frame `S:` + 3 heart-rate digits + 2 SpO2 digits + LF, and rebuilds binary heart-rate and SpO2 values. Sits behind the host-side UART RX and publishes the last good reading plus per-frame valid and error strobes.

---
 rtl/sensor_frame_decoder.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/sensor_frame_decoder.sv
// Parses "S:" + 3 HR digits + 2 SpO2 digits + LF (digits LSD first) into binary readings.
// Optional build macro SFD_RANGE_CHECK_EN adds a physiological range check (abort code 4).
module sensor_frame_decoder #(
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_byte,
  input  logic        rx_valid,
  output logic [15:0] heart_rate,
  output logic [7:0]  spo2,
  output logic        frame_valid,
  output logic        frame_error,
  output logic [2:0]  err_code,
  output logic [15:0] frame_count,
  output logic [7:0]  err_count
);

  localparam int TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [7:0] CH_S  = 8'h53;
  localparam logic [7:0] CH_CO = 8'h3A;
  localparam logic [7:0] CH_LF = 8'h0A;

  localparam logic [2:0] ERR_DELIM = 3'd0;
  localparam logic [2:0] ERR_DIGIT = 3'd1;
  localparam logic [2:0] ERR_TERM  = 3'd2;
  localparam logic [2:0] ERR_TOUT  = 3'd3;
`ifdef SFD_RANGE_CHECK_EN
  localparam logic [2:0] ERR_RANGE = 3'd4;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_DELIM,
    S_DIGIT,
    S_TERM
  } state_t;

  state_t        state, state_nx;
  logic [2:0]    idx, idx_nx;
  logic [9:0]    hr_w, hr_nx;
  logic [6:0]    sp_w, sp_nx;
  logic [TW-1:0] tcnt;

  logic       accept;
  logic       abort;
  logic [2:0] abort_code;
  logic       timeout;
  logic       is_s;
  logic       is_digit;
  logic [3:0] digit;

  assign is_s     = (rx_byte == CH_S);
  assign is_digit = (rx_byte >= 8'h30) && (rx_byte <= 8'h39);
  assign digit    = rx_byte[3:0];

  // A byte in the expiry cycle takes priority, so expiry requires an idle cycle.
  assign timeout = (state != S_IDLE) && !rx_valid &&
                   (tcnt == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_nx   = state;
    idx_nx     = idx;
    hr_nx      = hr_w;
    sp_nx      = sp_w;
    accept     = 1'b0;
    abort      = 1'b0;
    abort_code = ERR_DELIM;

    if (rx_valid) begin
      unique case (state)
        S_IDLE: begin
          if (is_s) state_nx = S_DELIM;
        end
        S_DELIM: begin
          if (rx_byte == CH_CO) begin
            state_nx = S_DIGIT;
            idx_nx   = 3'd0;
          end else begin
            abort      = 1'b1;
            abort_code = ERR_DELIM;
          end
        end
        S_DIGIT: begin
          if (is_digit) begin
            unique case (idx)
              3'd0:    hr_nx = 10'(digit);
              3'd1:    hr_nx = hr_w + 10'(digit) * 10'd10;
              3'd2:    hr_nx = hr_w + 10'(digit) * 10'd100;
              3'd3:    sp_nx = 7'(digit);
              default: sp_nx = sp_w + 7'(digit) * 7'd10;
            endcase
            if (idx == 3'd4) begin
              state_nx = S_TERM;
              idx_nx   = 3'd0;
            end else begin
              idx_nx = idx + 3'd1;
            end
          end else begin
            abort      = 1'b1;
            abort_code = ERR_DIGIT;
          end
        end
        default: begin
          if (rx_byte == CH_LF) begin
`ifdef SFD_RANGE_CHECK_EN
            if (hr_w < 10'd30 || hr_w > 10'd250 || sp_w < 7'd50 || sp_w > 7'd99) begin
              abort      = 1'b1;
              abort_code = ERR_RANGE;
            end else begin
              accept = 1'b1;
            end
`else
            accept = 1'b1;
`endif
          end else begin
            abort      = 1'b1;
            abort_code = ERR_TERM;
          end
        end
      endcase
    end else if (timeout) begin
      abort      = 1'b1;
      abort_code = ERR_TOUT;
    end

    // An offending 'S' is treated as the start of the next frame.
    if (abort) begin
      state_nx = (rx_valid && is_s) ? S_DELIM : S_IDLE;
      idx_nx   = 3'd0;
      hr_nx    = '0;
      sp_nx    = '0;
    end else if (accept) begin
      state_nx = S_IDLE;
      idx_nx   = 3'd0;
      hr_nx    = '0;
      sp_nx    = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      idx   <= '0;
      hr_w  <= '0;
      sp_w  <= '0;
      tcnt  <= '0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
      hr_w  <= hr_nx;
      sp_w  <= sp_nx;
      if (rx_valid || state == S_IDLE || timeout) tcnt <= '0;
      else                                        tcnt <= tcnt + TW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      heart_rate  <= '0;
      spo2        <= '0;
      frame_valid <= 1'b0;
      frame_error <= 1'b0;
      err_code    <= '0;
      frame_count <= '0;
      err_count   <= '0;
    end else begin
      frame_valid <= accept;
      frame_error <= abort;
      if (accept) begin
        heart_rate  <= {6'd0, hr_w};
        spo2        <= {1'b0, sp_w};
        frame_count <= frame_count + 16'd1;
      end
      if (abort) begin
        err_code <= abort_code;
        if (err_count != 8'hFF) err_count <= err_count + 8'd1;
      end
    end
  end

endmodule
